sync_fifo_ctrl: RTL and testbench

SYNC_FIFO_CTRL -- requirements
Module: sync_fifo_ctrl

---
 rtl/sync_fifo_ctrl.sv | 156 +++++++++++++++
 tb/tb_sync_fifo_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - synchronous single-clock FIFO controller with show-ahead output
//
// Purpose: DEPTH x WIDTH FIFO with registered occupancy count, decoded status
// flags and optional sticky overflow/underflow error flags.
//
// Optional feature macro: SYNC_FIFO_ERR_FLAG_EN
//   defined   -> overflow/underflow are sticky error registers cleared by err_clr
//   undefined -> overflow/underflow tied low, err_clr ignored
//
// Ports:
//   clk          - single clock, all state updates on rising edge
//   rst_n        - synchronous active-low reset
//   enable       - request qualifier when SLEEP_MODE=1, ignored otherwise
//   wr_en        - write request, one entry per cycle
//   data_in      - write data
//   rd_en        - read request, one entry per cycle
//   data_out     - oldest stored entry (show-ahead), zero when empty
//   full, empty, almost_full, almost_empty - status flags from registered count
//   count        - current occupancy
//   overflow     - sticky: write rejected while full
//   underflow    - sticky: read rejected while empty
//   err_clr      - clears the sticky error flags
module sync_fifo_ctrl #(
    parameter int DEPTH      = 16,
    parameter int WIDTH      = 8,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int SLEEP_MODE = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       err_clr
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [0:DEPTH-1];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic req_ok;
    logic wr_req, rd_req;
    logic wr_acc, rd_acc;

    // In sleep mode a deasserted enable makes requests invisible, so they
    // neither move data nor count as rejected for the error flags.
    assign req_ok = (SLEEP_MODE != 0) ? enable : 1'b1;

    always_comb begin
        wr_req   = wr_en & req_ok;
        rd_req   = rd_en & req_ok;
        rd_acc   = rd_req & ~empty;
        // A full FIFO still takes a write when a read frees a slot this cycle.
        wr_acc   = wr_req & (~full | rd_acc);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // Explicit wrap: DEPTH need not be a power of two.
        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset; the pointers and count define
    // which entries are meaningful.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign count        = count_q;
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AF_LEVEL));
    assign almost_empty = (count_q <= CW'(AE_LEVEL));
    assign data_out     = empty ? '0 : mem_q[rd_ptr_q];

`ifdef SYNC_FIFO_ERR_FLAG_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // A new error event wins over a same-cycle clear so it is never lost.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_req && !wr_acc) begin
            overflow_d = 1'b1;
        end
        if (rd_req && !rd_acc) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb/tb_sync_fifo_ctrl.sv - scoreboard bench for sync_fifo_ctrl against a queue model
module tb_sync_fifo_ctrl;

    localparam int DEPTH = 5;
    localparam int AF    = 4;
    localparam int AE    = 1;
`ifdef SYNC_FIFO_ERR_FLAG_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       wr_en;
    logic [7:0] data_in;
    logic       rd_en;
    logic [7:0] data_out;
    logic       full, empty, almost_full, almost_empty;
    logic [2:0] count;
    logic       overflow, underflow;
    logic       err_clr;

    always #5 clk = ~clk;

    sync_fifo_ctrl #(
        .DEPTH(DEPTH), .WIDTH(8), .AF_LEVEL(AF), .AE_LEVEL(AE), .SLEEP_MODE(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en),
        .data_in(data_in), .rd_en(rd_en), .data_out(data_out),
        .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
    );

    typedef struct packed {
        logic [2:0] cnt;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic [7:0] dout;
        logic       ov;
        logic       uf;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] fifo_m[$];
    bit         ov_m, uf_m;
    int         vectors     = 0;
    int         miscompares = 0;

    // Reference model: a plain queue plus two sticky bits, updated from the
    // pre-edge state and the inputs of one cycle.
    task automatic step(input bit rst, input bit en, input bit we,
                        input logic [7:0] din, input bit re, input bit clr);
        bit   wreq, rreq, racc, wacc;
        exp_t e;
        @(negedge clk);
        rst_n   = ~rst;
        enable  = en;
        wr_en   = we;
        data_in = din;
        rd_en   = re;
        err_clr = clr;
        if (rst) begin
            fifo_m.delete();
            ov_m = 1'b0;
            uf_m = 1'b0;
        end else begin
            wreq = we && en;
            rreq = re && en;
            racc = rreq && (fifo_m.size() > 0);
            wacc = wreq && ((fifo_m.size() < DEPTH) || racc);
            if (racc) void'(fifo_m.pop_front());
            if (wacc) fifo_m.push_back(din);
            if (ERR_EN) begin
                if (clr) begin
                    ov_m = 1'b0;
                    uf_m = 1'b0;
                end
                if (wreq && !wacc) ov_m = 1'b1;
                if (rreq && !racc) uf_m = 1'b1;
            end
        end
        e.cnt   = 3'(fifo_m.size());
        e.full  = (fifo_m.size() == DEPTH);
        e.empty = (fifo_m.size() == 0);
        e.af    = (fifo_m.size() >= AF);
        e.ae    = (fifo_m.size() <= AE);
        e.dout  = (fifo_m.size() == 0) ? 8'h00 : fifo_m[0];
        e.ov    = ov_m;
        e.uf    = uf_m;
        exp_q.push_back(e);
    endtask

    task automatic cmp(input string name, input int act, input int req, inout bit bad);
        if (act != req) begin
            $display("FAIL %s t=%0t actual=0x%0h required=0x%0h", name, $time, act, req);
            bad = 1'b1;
        end
    endtask

    // Monitor: the DUT presents its full output state after every edge.
    initial begin
        exp_t e;
        bit   bad;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                bad = 1'b0;
                cmp("count",        int'(count),        int'(e.cnt),   bad);
                cmp("full",         int'(full),         int'(e.full),  bad);
                cmp("empty",        int'(empty),        int'(e.empty), bad);
                cmp("almost_full",  int'(almost_full),  int'(e.af),    bad);
                cmp("almost_empty", int'(almost_empty), int'(e.ae),    bad);
                cmp("data_out",     int'(data_out),     int'(e.dout),  bad);
                cmp("overflow",     int'(overflow),     int'(e.ov),    bad);
                cmp("underflow",    int'(underflow),    int'(e.uf),    bad);
                vectors++;
                if (bad) miscompares++;
            end
        end
    end

    initial begin
        int wp;
        rst_n = 1'b0; enable = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        data_in = 8'h00; err_clr = 1'b0;

        step(1, 1, 0, 8'h00, 0, 0);
        step(1, 1, 1, 8'hEE, 1, 0);
        step(0, 1, 0, 8'h00, 0, 0);

        // fill 0x11..0x15, then simultaneous read/write at full (wraps 4->0)
        for (int i = 0; i < 5; i++) step(0, 1, 1, 8'(8'h11 + i), 0, 0);
        step(0, 1, 1, 8'h16, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 8'h00, 1, 0);

        // read while empty, clear, then read+write on empty
        step(0, 1, 0, 8'h00, 1, 0);
        step(0, 1, 0, 8'h00, 0, 1);
        step(0, 1, 1, 8'hA5, 1, 0);
        step(0, 1, 0, 8'h00, 0, 0);

        // fill to full, rejected write, clear pulse with set priority check
        for (int i = 0; i < 4; i++) step(0, 1, 1, 8'(8'h40 + i), 0, 0);
        step(0, 1, 1, 8'h77, 0, 0);
        step(0, 1, 0, 8'h00, 0, 1);
        step(0, 1, 1, 8'h78, 0, 1);
        step(0, 1, 0, 8'h00, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 8'h00, 1, 0);

        // mid-operation reset discards entries
        step(1, 1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 8'(8'h30 + i), 0, 0);
        step(1, 1, 0, 8'h00, 0, 0);
        step(0, 1, 1, 8'h3C, 0, 0);
        step(0, 1, 0, 8'h00, 1, 0);

        // sleep: enable low masks requests entirely
        for (int i = 0; i < 3; i++) step(0, 0, 1, 8'h99, 0, 0);
        step(0, 0, 0, 8'h00, 1, 0);
        step(0, 1, 1, 8'h5A, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 8'h9A, 1, 0);

        // random traffic with write bias changing per phase
        wp = 50;
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) wp = $urandom_range(10, 90);
            step($urandom_range(0, 149) == 0,
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 99) < wp,
                 8'($urandom),
                 $urandom_range(0, 99) < (100 - wp),
                 $urandom_range(0, 19) == 0);
        end

        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            $display("FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
